// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: request-to-send, bit shifting on device clocks,
// ACK check and return-to-idle wait, driving both pads open-drain.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 10_000,
  parameter int TIMEOUT_CYCLES = 2_000_000,
  parameter int FILTER_LEN     = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  output logic       tx_done,
  output logic       tx_error,
  output logic       busy,
  input  logic       PS2_clk_in,
  input  logic       PS2_data_in,
  output logic       PS2_clk_oe,
  output logic       PS2_data_oe
);

  localparam int INH_W = (INHIBIT_CYCLES > 1) ? $clog2(INHIBIT_CYCLES) : 1;
  localparam int TO_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int FLT_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

  localparam logic [INH_W-1:0] INH_LAST  = INH_W'(INHIBIT_CYCLES - 1);
  localparam logic [INH_W-1:0] INH_START = INH_W'(INHIBIT_CYCLES - 2);
  localparam logic [TO_W-1:0]  TO_LAST   = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [FLT_W-1:0] FLT_LAST  = FLT_W'(FILTER_LEN - 1);

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    RTS,
    WAIT_IDLE,
    DONE,
    ERR
  } state_t;

  function automatic logic [INH_W-1:0] inh_sat_inc(input logic [INH_W-1:0] v);
    return (v == INH_LAST) ? v : v + 1'b1;
  endfunction

  function automatic logic [TO_W-1:0] to_sat_inc(input logic [TO_W-1:0] v);
    return (v == TO_LAST) ? v : v + 1'b1;
  endfunction

  // Index 0 is the clock line, index 1 the data line.
  logic [1:0]       sync_p0;
  logic [1:0]       sync_p1;
  logic [1:0]       filt_p2;
  logic [FLT_W-1:0] run_cnt [2];
  logic             fall_p3;

  // Stage p0/p1: two-flop synchronizer; p2: run-length filter; p3: falling-edge strobe
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_p0    <= 2'b11;
      sync_p1    <= 2'b11;
      filt_p2    <= 2'b11;
      run_cnt[0] <= '0;
      run_cnt[1] <= '0;
      fall_p3    <= 1'b0;
    end else begin
      sync_p0 <= {PS2_data_in, PS2_clk_in};
      sync_p1 <= sync_p0;
      fall_p3 <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        if (sync_p1[i] == filt_p2[i]) begin
          run_cnt[i] <= '0;
        end else if (run_cnt[i] == FLT_LAST) begin
          filt_p2[i] <= sync_p1[i];
          run_cnt[i] <= '0;
          if (i == 0 && !sync_p1[i]) fall_p3 <= 1'b1;
        end else begin
          run_cnt[i] <= run_cnt[i] + 1'b1;
        end
      end
    end
  end

  state_t           state;
  logic [7:0]       shift_q;
  logic             parity_q;
  logic [3:0]       bit_cnt;
  logic [INH_W-1:0] inh_cnt;
  logic [TO_W-1:0]  to_cnt;
  logic             clk_oe_q;
  logic             data_oe_q;
  logic             ready_q;
  logic             done_q;
  logic             err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      shift_q   <= '0;
      parity_q  <= 1'b0;
      bit_cnt   <= '0;
      inh_cnt   <= '0;
      to_cnt    <= '0;
      clk_oe_q  <= 1'b0;
      data_oe_q <= 1'b0;
      ready_q   <= 1'b1;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state)
        IDLE: begin
          if (tx_valid && ready_q) begin
            state    <= INHIBIT;
            ready_q  <= 1'b0;
            clk_oe_q <= 1'b1;
            shift_q  <= tx_data;
            parity_q <= ~^tx_data;
            bit_cnt  <= '0;
            inh_cnt  <= '0;
          end
        end
        INHIBIT: begin
          inh_cnt <= inh_sat_inc(inh_cnt);
          // Start bit goes out one cycle before the clock is released.
          if (inh_cnt == INH_START) data_oe_q <= 1'b1;
          if (inh_cnt == INH_LAST) begin
            clk_oe_q  <= 1'b0;
            data_oe_q <= 1'b1;
            to_cnt    <= '0;
            state     <= RTS;
          end
        end
        RTS: begin
          to_cnt <= to_sat_inc(to_cnt);
          if (to_cnt == TO_LAST) begin
            clk_oe_q  <= 1'b0;
            data_oe_q <= 1'b0;
            err_q     <= 1'b1;
            state     <= ERR;
          end else if (fall_p3) begin
            if (bit_cnt != 4'd10) bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt <= 4'd7) begin
              data_oe_q <= ~shift_q[0];
              shift_q   <= {1'b0, shift_q[7:1]};
            end else if (bit_cnt == 4'd8) begin
              data_oe_q <= ~parity_q;
            end else if (bit_cnt == 4'd9) begin
              data_oe_q <= 1'b0;
            end else begin
              data_oe_q <= 1'b0;
              if (!filt_p2[1]) begin
                state <= WAIT_IDLE;
              end else begin
                err_q <= 1'b1;
                state <= ERR;
              end
            end
          end
        end
        WAIT_IDLE: begin
          to_cnt    <= to_sat_inc(to_cnt);
          clk_oe_q  <= 1'b0;
          data_oe_q <= 1'b0;
          if (to_cnt == TO_LAST) begin
            err_q <= 1'b1;
            state <= ERR;
          end else if (&filt_p2) begin
            done_q <= 1'b1;
            state  <= DONE;
          end
        end
        DONE: begin
          ready_q <= 1'b1;
          state   <= IDLE;
        end
        ERR: begin
          clk_oe_q  <= 1'b0;
          data_oe_q <= 1'b0;
          ready_q   <= 1'b1;
          state     <= IDLE;
        end
        default: begin
          clk_oe_q  <= 1'b0;
          data_oe_q <= 1'b0;
          ready_q   <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end

  assign tx_ready    = ready_q;
  assign busy        = ~ready_q;
  assign tx_done     = done_q;
  assign tx_error    = err_q;
  assign PS2_clk_oe  = clk_oe_q;
  assign PS2_data_oe = data_oe_q;

endmodule
